// File: rtl/fec_viterbi_decoder_pkg.sv
// rtl/fec_viterbi_decoder_pkg.sv - shared constants, FSM states and code-pair helper for the K=7 Viterbi decoder
package fec_pkg;

  localparam int BLOCK_BITS = 96;
  localparam int CODED_BITS = 192;
  localparam int K          = 7;

  localparam logic [K-1:0] G1 = 7'o171;
  localparam logic [K-1:0] G2 = 7'o133;

  typedef enum logic [2:0] {
    COLLECT,
    PASS1,
    PASS2,
    FIND,
    TRACE,
    OUTPUT
  } dec_state_e;

  // Expected {X,Y} when input u leaves state s; register vector is {u, s5..s0}.
  function automatic logic [1:0] code_pair(input logic u, input logic [5:0] s);
    logic [K-1:0] r;
    r = {u, s};
    return {^(r & G1), ^(r & G2)};
  endfunction

endpackage

// File: rtl/fec_viterbi_decoder_if.sv
// rtl/fec_viterbi_decoder_if.sv - coded-bit input and decoded-bit output handshake bundle
interface fec_viterbi_decoder_if;

  logic in_valid;
  logic data_in;
  logic in_ready;
  logic out_valid;
  logic data_out;
  logic block_done;

  modport master (
    output in_valid, data_in,
    input  in_ready, out_valid, data_out, block_done
  );

  modport slave (
    input  in_valid, data_in,
    output in_ready, out_valid, data_out, block_done
  );

endinterface

// File: rtl/fec_viterbi_decoder_acs.sv
// rtl/fec_viterbi_decoder_acs.sv - add-compare-select for one trellis state with modulo metrics
module fec_acs #(
  parameter int METRIC_W = 8
) (
  input  logic [METRIC_W-1:0] pm0,
  input  logic [METRIC_W-1:0] pm1,
  input  logic [1:0]          bm0,
  input  logic [1:0]          bm1,
  output logic [METRIC_W-1:0] pm_new,
  output logic                decision
);

  logic [METRIC_W-1:0] cand0;
  logic [METRIC_W-1:0] cand1;
  logic [METRIC_W-1:0] diff;

  assign cand0 = pm0 + METRIC_W'(bm0);
  assign cand1 = pm1 + METRIC_W'(bm1);

  // Wrapped metrics compare by the sign of their difference; ties keep the b=0 path.
  assign diff     = cand1 - cand0;
  assign decision = diff[METRIC_W-1];
  assign pm_new   = decision ? cand1 : cand0;

endmodule

// File: rtl/fec_viterbi_decoder.sv
// rtl/fec_viterbi_decoder.sv - hard-decision tail-biting Viterbi decoder, two-pass wrap, serial in/out
module fec_viterbi_decoder #(
  parameter int BLOCK_BITS = 96,
  parameter int METRIC_W   = 8
) (
  input logic                  clock_a,
  input logic                  reset,
  fec_viterbi_decoder_if.slave bus
);
  import fec_pkg::*;

  localparam int NS = 64;
  localparam int CB = 2 * BLOCK_BITS;

  dec_state_e                     state;
  logic [7:0]                     cnt;
  logic [CB-1:0]                  rx_buf;
  logic [NS-1:0][METRIC_W-1:0]    pm;
  logic [NS-1:0][METRIC_W-1:0]    pm_next;
  logic [NS-1:0]                  decision;
  logic [NS-1:0]                  surv [BLOCK_BITS];
  logic [BLOCK_BITS-1:0]          dec_bits;
  logic [METRIC_W-1:0]            best_pm;
  logic [METRIC_W-1:0]            scan_diff;
  logic                           scan_less;
  logic [5:0]                     best_state;
  logic [5:0]                     trace_st;
  logic                           in_ready_r;
  logic                           out_valid_r;
  logic                           data_out_r;
  logic                           block_done_r;
  logic                           rx_x;
  logic                           rx_y;

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.data_out   = data_out_r;
  assign bus.block_done = block_done_r;

  assign rx_x = rx_buf[{cnt[6:0], 1'b0}];
  assign rx_y = rx_buf[{cnt[6:0], 1'b1}];

  assign scan_diff = pm[cnt[5:0]] - best_pm;
  assign scan_less = scan_diff[METRIC_W-1];

  for (genvar t = 0; t < NS; t++) begin : g_acs
    localparam int         P0 = (2 * t) % NS;
    localparam logic [1:0] E0 = code_pair(1'(t / 32), 6'(P0));
    localparam logic [1:0] E1 = code_pair(1'(t / 32), 6'(P0 + 1));

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = {1'b0, rx_x ^ E0[1]} + {1'b0, rx_y ^ E0[0]};
    assign bm1 = {1'b0, rx_x ^ E1[1]} + {1'b0, rx_y ^ E1[0]};

    fec_acs #(.METRIC_W(METRIC_W)) u_acs (
      .pm0      (pm[P0]),
      .pm1      (pm[P0 + 1]),
      .bm0      (bm0),
      .bm1      (bm1),
      .pm_new   (pm_next[t]),
      .decision (decision[t])
    );
  end

  always_ff @(posedge clock_a or posedge reset) begin
    if (reset) begin
      state        <= COLLECT;
      cnt          <= '0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      data_out_r   <= 1'b0;
      block_done_r <= 1'b0;
      best_pm      <= '0;
      best_state   <= '0;
      trace_st     <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            if (cnt == 8'(CB - 1)) begin
              cnt        <= '0;
              in_ready_r <= 1'b0;
              state      <= PASS1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        PASS1: begin
          if (cnt == 8'(BLOCK_BITS - 1)) begin
            cnt   <= '0;
            state <= PASS2;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PASS2: begin
          if (cnt == 8'(BLOCK_BITS - 1)) begin
            cnt   <= '0;
            state <= FIND;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FIND: begin
          if (cnt == 8'd0 || scan_less) begin
            best_pm    <= pm[cnt[5:0]];
            best_state <= cnt[5:0];
          end
          // The last candidate is folded in directly so traceback can start next cycle.
          if (cnt == 8'(NS - 1)) begin
            trace_st <= scan_less ? cnt[5:0] : best_state;
            cnt      <= 8'(BLOCK_BITS - 1);
            state    <= TRACE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        TRACE: begin
          trace_st <= {trace_st[4:0], surv[cnt[6:0]][trace_st]};
          if (cnt == 8'd0) begin
            state <= OUTPUT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        OUTPUT: begin
          if (cnt == 8'(BLOCK_BITS)) begin
            out_valid_r  <= 1'b0;
            block_done_r <= 1'b0;
            in_ready_r   <= 1'b1;
            cnt          <= '0;
            state        <= COLLECT;
          end else begin
            out_valid_r  <= 1'b1;
            data_out_r   <= dec_bits[cnt[6:0]];
            block_done_r <= (cnt == 8'(BLOCK_BITS - 1));
            cnt          <= cnt + 8'd1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Storage arrays carry no reset; their contents are rebuilt for every block.
  always_ff @(posedge clock_a) begin
    if (state == COLLECT && bus.in_valid) begin
      rx_buf[cnt] <= bus.data_in;
      if (cnt == 8'(CB - 1)) begin
        pm <= '0;
      end
    end
    if (state == PASS1 || state == PASS2) begin
      pm <= pm_next;
    end
    if (state == PASS2) begin
      surv[cnt[6:0]] <= decision;
    end
    if (state == TRACE) begin
      dec_bits[cnt[6:0]] <= trace_st[5];
    end
  end

endmodule

// File: tb/tb_fec_viterbi_decoder.sv
// tb/tb_fec_viterbi_decoder.sv - randomized self-checking bench with a tail-biting encoder reference
module tb_fec_viterbi_decoder;

  logic clock_a = 1'b0;
  logic reset   = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   last_acc = 0;

  fec_viterbi_decoder_if bus ();

  fec_viterbi_decoder #(.BLOCK_BITS(96), .METRIC_W(8)) dut (
    .clock_a (clock_a),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock_a = ~clock_a;
  always @(posedge clock_a) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Tail-biting encoder: register preloaded with the last six info bits.
  function automatic logic [191:0] encode(input logic [95:0] u);
    logic [5:0]   s;
    logic [191:0] c;
    s = u[95:90];
    c = '0;
    for (int n = 0; n < 96; n++) begin
      c[2*n]   = u[n] ^ s[0] ^ s[3] ^ s[4] ^ s[5];
      c[2*n+1] = u[n] ^ s[0] ^ s[1] ^ s[3] ^ s[4];
      s = {u[n], s[5:1]};
    end
    return c;
  endfunction

  task automatic send_block(input string tag, input logic [191:0] c, input bit gaps);
    int   i = 0;
    int   guard = 0;
    logic rdy;
    logic drove;
    while (i < 192 && guard < 5000) begin
      rdy = bus.in_ready;
      if (gaps && $urandom_range(0, 3) == 0) begin
        drove = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = 1'($urandom);
      end else begin
        drove = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in  = c[i];
      end
      @(negedge clock_a);
      guard++;
      if (drove && rdy) begin
        i++;
        if (i == 192) last_acc = cyc;
      end
    end
    bus.in_valid = 1'b0;
    bus.data_in  = 1'b0;
    check_eq({tag, ".sent"}, i, 192);
  endtask

  task automatic recv_block(input string tag, input logic [95:0] exp, input bit extra);
    logic [95:0] got = '0;
    int n = 0;
    int first = -1;
    int done_at = -1;
    int done_cnt = 0;
    int rdy_busy = 0;
    int guard = 0;
    while (n < 96 && guard < 2000) begin
      if (bus.in_ready) rdy_busy++;
      if (bus.block_done) begin
        done_cnt++;
        done_at = n;
      end
      if (bus.out_valid) begin
        got[n] = bus.data_out;
        if (first < 0) first = cyc;
        n++;
      end
      if (extra) begin
        bus.in_valid = 1'($urandom);
        bus.data_in  = 1'($urandom);
      end
      @(negedge clock_a);
      guard++;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, ".count"}, n, 96);
    check_eq({tag, ".data"}, got, exp);
    check_eq({tag, ".latency"}, first - last_acc, 353);
    check_eq({tag, ".done_at"}, done_at, 95);
    check_eq({tag, ".done_cnt"}, done_cnt, 1);
    check_eq({tag, ".busy_ready"}, rdy_busy, 0);
    check_eq({tag, ".ready_back"}, bus.in_ready, 1'b1);
    check_eq({tag, ".valid_low"}, bus.out_valid, 1'b0);
    check_eq({tag, ".ready_cycle"}, cyc - last_acc, 449);
  endtask

  task automatic run_block(input string tag, input logic [95:0] info, input logic [191:0] err,
                           input bit gaps, input bit extra);
    send_block(tag, encode(info) ^ err, gaps);
    recv_block(tag, info, extra);
  endtask

  initial begin
    logic [95:0]  info;
    logic [95:0]  pat;
    logic [191:0] err;
    int           stray;

    bus.in_valid = 1'b0;
    bus.data_in  = 1'b0;
    repeat (3) @(negedge clock_a);
    check_eq("rst.in_ready", bus.in_ready, 1'b1);
    check_eq("rst.out_valid", bus.out_valid, 1'b0);
    check_eq("rst.data_out", bus.data_out, 1'b0);
    check_eq("rst.block_done", bus.block_done, 1'b0);
    reset = 1'b0;
    @(negedge clock_a);

    run_block("zero", '0, '0, 1'b0, 1'b0);

    pat = {12{8'hA5}};
    run_block("a5", pat, '0, 1'b0, 1'b0);

    err = '0;
    err[37] = 1'b1;
    run_block("a5_err37", pat, err, 1'b0, 1'b0);

    err = '0;
    err[10]  = 1'b1;
    err[150] = 1'b1;
    run_block("a5_err10_150", pat, err, 1'b0, 1'b0);

    info = {$urandom, $urandom, $urandom};
    run_block("rand_gaps", info, '0, 1'b1, 1'b1);

    info = {$urandom, $urandom, $urandom};
    send_block("abort", encode(info), 1'b0);
    stray = 0;
    repeat (140) begin
      if (bus.out_valid) stray++;
      @(negedge clock_a);
    end
    reset = 1'b1;
    @(negedge clock_a);
    reset = 1'b0;
    @(negedge clock_a);
    check_eq("abort.in_ready", bus.in_ready, 1'b1);
    check_eq("abort.out_valid", bus.out_valid, 1'b0);
    repeat (500) begin
      if (bus.out_valid) stray++;
      @(negedge clock_a);
    end
    check_eq("abort.no_output", stray, 0);

    info = {$urandom, $urandom, $urandom};
    run_block("after_abort", info, '0, 1'b0, 1'b0);

    for (int b = 0; b < 3; b++) begin
      info = {$urandom, $urandom, $urandom};
      run_block($sformatf("b2b%0d", b), info, '0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fec_viterbi_decoder.md
Name: fec_viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the rate-1/2, K=7 tail-biting convolutional code (G1=171 octal for X, G2=133 octal for Y) used by the WiMAX FEC encoder.
- Sits after the demapper/deinterleaver on the receive path. Consumes one 192-bit coded block serially and emits the 96 decoded bits serially.
- Runs in a single clock domain. Tail-biting is handled with a two-pass wrap-around on a stored copy of the received block.

Parameters:
- BLOCK_BITS, 96, information bits per block.
- METRIC_W, 8, path-metric width; metrics use modulo arithmetic.

Ports:
- clock_a  input  1  block clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  data_in carries a coded bit this cycle.
- data_in  input  1  coded bit; order is X0,Y0,X1,Y1,…,X95,Y95.
- in_ready  output  1  block accepts coded bits; in_valid while low is ignored.
- out_valid  output  1  data_out carries a decoded bit.
- data_out  output  1  decoded bit, u0 first.
- block_done  output  1  one-cycle pulse with the last decoded bit (u95).

Behaviour:
- Reset:
  - FSM goes to COLLECT; all counters are 0.
  - in_ready=1; out_valid=0, data_out=0, block_done=0.
  - Metrics, survivor memory and received buffer are don't-care.
- Trellis definition:
  - state s[5:0], where s[5]=u(n-1) and s[0]=u(n-6).
  - X = u ^ s0 ^ s3 ^ s4 ^ s5; Y = u ^ s0 ^ s1 ^ s3 ^ s4.
  - next state = {u, s[5:1]}.
  - Predecessors of state t: {t[4:0], b} for b in {0,1}; input bit u = t[5].
- Branch metric: Hamming distance (0..2) between the received (X,Y) pair and the expected pair.
- ACS:
  - All 64 states are updated in parallel, one trellis step per cycle.
  - Metric addition is modulo 2^METRIC_W.
  - "a < b" is decided by the MSB of (a-b).
  - On a tie, take the b=0 predecessor.
  - The decision bit b is written to survivor memory [step][t].
- FSM (1-hot or encoded, implementer's choice):
  - COLLECT:
    - in_ready=1; each accepted bit goes to rx_buf[cnt], and cnt increments.
    - On accepting bit 191: cnt←0, go to PASS1.
  - PASS1:
    - 96 cycles of ACS; metrics start at all-zero.
    - Survivors are not kept.
    - Then go to PASS2, keeping the metrics.
  - PASS2:
    - 96 cycles of ACS over the same rx_buf, continuing from the PASS1 metrics.
    - Survivors are written for steps 0..95.
  - FIND:
    - 64-cycle sequential scan for the minimum metric.
    - Lowest state index wins ties.
    - Result is best_state.
  - TRACE:
    - 96 cycles, k from 95 down to 0.
    - dec[k] ← t[5]; t ← {t[4:0], surv[k][t]}.
    - Starts with t = best_state.
  - OUTPUT:
    - 96 cycles; out_valid=1, data_out=dec[i] for i=0..95.
    - block_done=1 at i=95.
    - Next cycle: COLLECT with in_ready=1.
- Latency (cycle 0 = edge accepting coded bit 191):
  - out_valid rises registered at cycle 353 and stays high through 448.
  - in_ready=1 from cycle 449.
  - in_ready=0 during cycles 1..448.
- Boundaries:
  - in_valid while in_ready=0 is dropped silently.
  - A partial block in COLLECT waits indefinitely; there is no timeout.
  - Reset in any state aborts immediately. No out_valid is produced for the aborted block, and the next block decodes normally.
  - out_valid has no backpressure; downstream must accept every bit.

Decomposition:
- Package fec_pkg holds:
  - BLOCK_BITS=96, CODED_BITS=192, K=7.
  - G1=7'o171, G2=7'o133.
  - The decoder FSM enum typedef {COLLECT, PASS1, PASS2, FIND, TRACE, OUTPUT}.
- Sub-module fec_acs (one state's add-compare-select) is instantiated 64× via generate. Its inputs are two predecessor metrics and two branch metrics; its outputs are the new metric and the decision bit.
- Survivor memory (96×64) and rx_buf (192) stay in the top module.

Test Plan:
- All-zero coded block (192 zeros) -> 96 zeros out; block_done with the 96th bit; out_valid first high 353 cycles after the last input.
- Info pattern 8'hA5 repeated (96 bits), tail-biting encoded by the bench model (shift register preloaded with u90..u95) -> decoded bits equal the input exactly, u0 first.
- Same block with coded bit 37 inverted -> error-free output.
- Same block with coded bits 10 and 150 inverted -> error-free output.
- Random 96-bit block, in_valid toggled with gaps in COLLECT, plus extra in_valid pulses during PASS2/OUTPUT -> correct decode; extra bits ignored; in_ready=0 throughout busy states.
- Reset asserted mid-PASS2 -> out_valid=0 and in_ready=1 right after reset; a subsequent clean block decodes correctly.
- Three back-to-back blocks fed as soon as in_ready rises -> three correct 96-bit outputs, each separated by ≥353 cycles of collect/decode.
